// File: rtl/chunk_stats_engine_if.sv
// Sample-store read port and per-chunk result port of chunk_stats_engine.
// master = engine side, slave = sample store / regression stage side.
interface chunk_stats_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [15:0]           res_id;
    logic [DATA_W:0]       res_mean;
    logic [2*DATA_W-1:0]   res_var;

    modport master (
        output rd_req, rd_addr, res_valid, res_id, res_mean, res_var,
        input  rd_valid, rd_data, res_ready
    );

    modport slave (
        input  rd_req, rd_addr, res_valid, res_id, res_mean, res_var,
        output rd_valid, rd_data, res_ready
    );
endinterface

// File: rtl/chunk_stats_engine.sv
// Per-chunk mean / population variance over a stored series; one read outstanding, results stall on res_ready.
// Optional CHUNK_STATS_REVERSE_EN adds a second, end-aligned pass read in descending address order.
module chunk_stats_engine #(
    parameter int DATA_W     = 32,
    parameter int N_DATA     = 20,
    parameter int CHUNK_LOG2 = 1,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    chunk_stats_engine_if.master  bus
);
    localparam int CHUNK  = 1 << CHUNK_LOG2;
    localparam int N_FULL = N_DATA >> CHUNK_LOG2;
    localparam int SUM_W  = DATA_W + CHUNK_LOG2;
    localparam int SQ_W   = 2 * DATA_W + CHUNK_LOG2;
    localparam int CNT_W  = CHUNK_LOG2 + 1;
    localparam int W      = SQ_W + 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CALC, EMIT, FIN} state_t;

    state_t                      state_q;
    logic                        busy_q, done_q, rd_req_q, res_valid_q;
    logic [ADDR_W-1:0]           rd_addr_q;
    logic [15:0]                 id_q, res_id_q;
    logic [CNT_W-1:0]            samp_q;
    logic signed [SUM_W-1:0]     sum_q;
    logic [SQ_W-1:0]             sumsq_q;
    logic [DATA_W:0]             res_mean_q;
    logic [2*DATA_W-1:0]         res_var_q;
`ifdef CHUNK_STATS_REVERSE_EN
    logic                        rev_q;
`endif

    logic signed [2*DATA_W-1:0]  data_x_d, sq_d;
    logic signed [W-1:0]         mean_x_d, var_x_d;
    logic [DATA_W:0]             mean_d;
    logic [2*DATA_W-1:0]         var_d;
    logic [ADDR_W-1:0]           next_addr_d;
    logic                        pass_end_d;

    always_comb begin
        data_x_d = (2*DATA_W)'($signed(bus.rd_data));
        sq_d     = data_x_d * data_x_d;
        // Floor mean; the variance can dip below zero from that rounding, so clamp.
        mean_x_d = W'(sum_q) >>> CHUNK_LOG2;
        var_x_d  = $signed(W'(sumsq_q >> CHUNK_LOG2)) - mean_x_d * mean_x_d;
        mean_d   = mean_x_d[DATA_W:0];
        var_d    = var_x_d[W-1] ? '0 : var_x_d[2*DATA_W-1:0];
        next_addr_d = rd_addr_q + ADDR_W'(1);
        pass_end_d  = (id_q == 16'(N_FULL - 1));
`ifdef CHUNK_STATS_REVERSE_EN
        if (rev_q) begin
            next_addr_d = rd_addr_q - ADDR_W'(1);
            pass_end_d  = (id_q == 16'(2 * N_FULL - 1));
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            res_valid_q <= 1'b0;
            rd_addr_q   <= '0;
            id_q        <= '0;
            res_id_q    <= '0;
            samp_q      <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            res_mean_q  <= '0;
            res_var_q   <= '0;
`ifdef CHUNK_STATS_REVERSE_EN
            rev_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q   <= ISSUE;
                    busy_q    <= 1'b1;
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= '0;
                    id_q      <= '0;
                    samp_q    <= '0;
                    sum_q     <= '0;
                    sumsq_q   <= '0;
`ifdef CHUNK_STATS_REVERSE_EN
                    rev_q     <= 1'b0;
`endif
                end
                ISSUE: begin
                    rd_req_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: if (bus.rd_valid) begin
                    sum_q   <= sum_q + SUM_W'($signed(bus.rd_data));
                    sumsq_q <= sumsq_q + SQ_W'(sq_d);
                    if (samp_q == CNT_W'(CHUNK - 1)) begin
                        state_q <= CALC;
                    end else begin
                        samp_q    <= samp_q + CNT_W'(1);
                        rd_addr_q <= next_addr_d;
                        rd_req_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                CALC: begin
                    res_valid_q <= 1'b1;
                    res_mean_q  <= mean_d;
                    res_var_q   <= var_d;
                    res_id_q    <= id_q;
                    state_q     <= EMIT;
                end
                EMIT: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    if (pass_end_d) begin
`ifdef CHUNK_STATS_REVERSE_EN
                        if (!rev_q) begin
                            rev_q     <= 1'b1;
                            id_q      <= id_q + 16'd1;
                            rd_addr_q <= ADDR_W'(N_DATA - 1);
                            samp_q    <= '0;
                            sum_q     <= '0;
                            sumsq_q   <= '0;
                            rd_req_q  <= 1'b1;
                            state_q   <= ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
`endif
                    end else begin
                        id_q      <= id_q + 16'd1;
                        rd_addr_q <= next_addr_d;
                        samp_q    <= '0;
                        sum_q     <= '0;
                        sumsq_q   <= '0;
                        rd_req_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_mean  = res_mean_q;
    assign bus.res_var   = res_var_q;
endmodule

// File: tb/tb_chunk_stats_engine.sv
// Bench for chunk_stats_engine (N_DATA=21, CHUNK_LOG2=1): sample-store responder plus result scoreboard.
module tb_chunk_stats_engine;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int ND = 21;
    localparam int CL = 1;
    localparam int CH = 1 << CL;
    localparam int NF = ND >> CL;
`ifdef CHUNK_STATS_REVERSE_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        int     id;
        longint mean;
        longint var_v;
    } exp_t;

    logic clk, rst, start, busy, done;
    chunk_stats_engine_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    chunk_stats_engine #(.DATA_W(DW), .N_DATA(ND), .CHUNK_LOG2(CL), .ADDR_W(AW)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (ifc.master)
    );

    int             errors = 0;
    int             checks = 0;
    logic signed [DW-1:0] mem [ND];
    int             rd_lat = 1;
    exp_t           exp_q[$];
    int             exp_addr_q[$];
    int             req_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample store: one pending read, returns rd_lat cycles after the request is accepted.
    initial begin
        int cnt;
        int paddr;
        cnt = 0;
        paddr = 0;
        ifc.rd_valid = 1'b0;
        ifc.rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            ifc.rd_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.rd_valid = 1'b1;
                    ifc.rd_data  = (paddr >= 0 && paddr < ND) ? mem[paddr] : '0;
                end
            end
            if (ifc.rd_req) begin
                paddr = int'(ifc.rd_addr);
                cnt   = rd_lat;
                req_q.push_back(paddr);
            end
        end
    end

    task automatic build_expected();
        exp_q.delete();
        exp_addr_q.delete();
        for (int p = 0; p < NPASS; p++) begin
            for (int k = 0; k < NF; k++) begin
                longint s, sq, m, v;
                exp_t e;
                s = 0;
                sq = 0;
                for (int j = 0; j < CH; j++) begin
                    int a;
                    a = (p == 0) ? k * CH + j : ND - 1 - k * CH - j;
                    exp_addr_q.push_back(a);
                    s  += longint'(mem[a]);
                    sq += longint'(mem[a]) * longint'(mem[a]);
                end
                m = s >>> CL;
                v = (sq >>> CL) - m * m;
                if (v < 0) v = 0;
                e.id = p * NF + k;
                e.mean = m;
                e.var_v = v;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_pass(input int lat, input int stall_idx, input int poke_cyc);
        int   n;
        int   st;
        bit   hs_prev;
        bit   finished;
        logic [15:0]       snap_id;
        logic [DW:0]       snap_mean;
        logic [2*DW-1:0]   snap_var;
        rd_lat = lat;
        req_q.delete();
        build_expected();
        n = 0;
        st = 0;
        hs_prev = 1'b0;
        finished = 1'b0;
        snap_id = '0;
        snap_mean = '0;
        snap_var = '0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ifc.rd_req !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL first_rd_req: rd_req=%b busy=%b, required 1 1", ifc.rd_req, busy); end
        checks++;
        if (ifc.rd_addr !== AW'(0))
            begin errors++; $display("FAIL first_addr: got %0d, required 0", ifc.rd_addr); end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == poke_cyc);
            if (done === 1'b1) begin
                finished = 1'b1;
                checks++;
                if (busy !== 1'b0)
                    begin errors++; $display("FAIL busy_with_done: busy=%b, required 0", busy); end
                checks++;
                if (exp_q.size() != 0)
                    begin errors++; $display("FAIL result_count: %0d results missing, required 0", exp_q.size()); end
                @(posedge clk); #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0)
                    begin errors++; $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done, busy); end
                break;
            end
            if (hs_prev) begin
                checks++;
                if (ifc.res_valid !== 1'b0)
                    begin errors++; $display("FAIL valid_gap: res_valid=%b after handshake, required 0", ifc.res_valid); end
            end
            hs_prev = 1'b0;
            if (ifc.res_valid === 1'b1) begin
                if (n == stall_idx && st < 5) begin
                    ifc.res_ready = 1'b0;
                    if (st == 0) begin
                        snap_id = ifc.res_id;
                        snap_mean = ifc.res_mean;
                        snap_var = ifc.res_var;
                    end else begin
                        checks++;
                        if (ifc.res_id !== snap_id || ifc.res_mean !== snap_mean || ifc.res_var !== snap_var)
                            begin errors++; $display("FAIL stall_stable: id=%0d mean=%0d var=%0d, required %0d %0d %0d",
                                ifc.res_id, $signed(ifc.res_mean), ifc.res_var, snap_id, $signed(snap_mean), snap_var); end
                    end
                    checks++;
                    if (ifc.rd_req !== 1'b0)
                        begin errors++; $display("FAIL stall_no_read: rd_req=%b, required 0", ifc.rd_req); end
                    st++;
                end else begin
                    exp_t e;
                    ifc.res_ready = 1'b1;
                    hs_prev = 1'b1;
                    n++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_result: id=%0d, required no result", ifc.res_id);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(ifc.res_id) != e.id)
                            begin errors++; $display("FAIL res_id: got %0d, required %0d", ifc.res_id, e.id); end
                        checks++;
                        if (longint'($signed(ifc.res_mean)) != e.mean)
                            begin errors++; $display("FAIL res_mean id %0d: got %0d, required %0d", e.id, $signed(ifc.res_mean), e.mean); end
                        checks++;
                        if (ifc.res_var !== 64'(e.var_v))
                            begin errors++; $display("FAIL res_var id %0d: got %0d, required %0d", e.id, ifc.res_var, e.var_v); end
                    end
                end
            end else begin
                ifc.res_ready = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (!finished)
            begin errors++; $display("FAIL timeout: done not seen, required done within 4000 cycles"); end
        checks++;
        if (req_q.size() != exp_addr_q.size())
            begin errors++; $display("FAIL read_count: got %0d reads, required %0d", req_q.size(), exp_addr_q.size()); end
        for (int i = 0; i < req_q.size() && i < exp_addr_q.size(); i++) begin
            checks++;
            if (req_q[i] != exp_addr_q[i])
                begin errors++; $display("FAIL read_addr[%0d]: got %0d, required %0d", i, req_q[i], exp_addr_q[i]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        ifc.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ifc.rd_req !== 1'b0 || ifc.res_valid !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl: busy=%b done=%b rd_req=%b res_valid=%b, required all 0",
                busy, done, ifc.rd_req, ifc.res_valid); end
        checks++;
        if (ifc.rd_addr !== '0 || ifc.res_id !== '0 || ifc.res_mean !== '0 || ifc.res_var !== '0)
            begin errors++; $display("FAIL reset_data: addr=%0d id=%0d mean=%0d var=%0d, required all 0",
                ifc.rd_addr, ifc.res_id, ifc.res_mean, ifc.res_var); end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        int hits;
        for (int i = 0; i < ND; i++) mem[i] = DW'(i);
        run_pass(1, -1, -1);
`ifndef CHUNK_STATS_REVERSE_EN
        hits = 0;
        foreach (req_q[i]) if (req_q[i] == ND - 1) hits++;
        checks++;
        if (hits != 0)
            begin errors++; $display("FAIL tail_skipped: address %0d read %0d times, required 0", ND - 1, hits); end
`endif
    endtask

    task automatic test_alternating();
        for (int i = 0; i < ND; i++) mem[i] = (i % 2 == 0) ? DW'(0) : DW'(4);
        run_pass(3, -1, 10);
    endtask

    task automatic test_negative_stall();
        for (int i = 0; i < ND; i++) mem[i] = (i % 2 == 0) ? -DW'(3) : -DW'(5);
        run_pass(2, 0, -1);
    endtask

    task automatic test_reset_midrun();
        int bad;
        for (int i = 0; i < ND; i++) mem[i] = DW'(i + 100);
        rd_lat = 4;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ifc.rd_req !== 1'b0 || ifc.res_valid !== 1'b0 || ifc.rd_addr !== '0)
            begin errors++; $display("FAIL midrun_reset: busy=%b rd_req=%b res_valid=%b addr=%0d, required 0 0 0 0",
                busy, ifc.rd_req, ifc.res_valid, ifc.rd_addr); end
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || ifc.rd_req !== 1'b0 || ifc.res_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL late_rd_valid: %0d active cycles after reset, required 0", bad); end
        run_pass(1, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < ND; i++) mem[i] = DW'(int'($urandom_range(2000)) - 1000);
            run_pass(int'($urandom_range(3, 1)), 3, -1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ifc.res_ready = 1'b0;
        for (int i = 0; i < ND; i++) mem[i] = '0;
        test_reset();
        test_ramp();
        test_alternating();
        test_negative_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
